// File: rtl/ip_match_engine_pkg.sv
// Shared types and sizing helpers for the byte-pattern match engine.
// Entry fields are stored at the maximum pattern width; unused upper mask bits stay zero.
package ip_match_engine_pkg;

  localparam int unsigned COUNT_W      = 16;
  localparam int unsigned MAX_PAT_BITS = 64;
  // Widest compare slice: offset 3 (24 bits) plus a full-width pattern.
  localparam int unsigned PAD_BITS     = MAX_PAT_BITS + 24;

  typedef struct packed {
    logic [MAX_PAT_BITS-1:0] pattern;
    logic [MAX_PAT_BITS-1:0] mask;
    logic                    enable;
  } entry_t;

  // Window depth in 32-bit words: ceil((pat_bytes + 3) / 4).
  function automatic int unsigned calc_words(input int unsigned pat_bytes);
    return (pat_bytes + 6) / 4;
  endfunction

endpackage

// File: rtl/ip_entry_compare.sv
// Evaluates one pattern entry against the stream window at byte offsets 0..3.
// The window is zero-padded so every offset compares a full-width slice.
module ip_entry_compare
  import ip_match_engine_pkg::*;
#(
  parameter int unsigned PAT_BYTES = 4
) (
  input  logic [24+8*PAT_BYTES-1:0] window,
  input  entry_t                    entry,
  output logic [3:0]                hit
);

  logic [PAD_BITS-1:0] padded;

  assign padded = PAD_BITS'(window);

  for (genvar k = 0; k < 4; k++) begin : g_off
    assign hit[k] = entry.enable &&
                    (((padded[8*k +: MAX_PAT_BITS] ^ entry.pattern) & entry.mask) == '0);
  end

endmodule

// File: rtl/ip_match_engine.sv
// Streaming multi-entry byte-pattern matcher: delays the stream by W-1 words and
// flags each emitted word in which an enabled entry's pattern starts.
module ip_match_engine
  import ip_match_engine_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned PAT_BYTES   = 4,
  localparam int unsigned IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   data_valid,
  input  logic [31:0]            data_in,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [PAT_BYTES*8-1:0] cfg_pattern,
  input  logic [PAT_BYTES*8-1:0] cfg_mask,
  input  logic                   cfg_enable,
  output logic [31:0]            data_out,
  output logic                   data_out_valid,
  output logic                   match,
  output logic [IDX_W-1:0]       match_idx,
  output logic [1:0]             match_offset,
  output logic [COUNT_W-1:0]     match_count
);

  localparam int unsigned W        = calc_words(PAT_BYTES);
  localparam int unsigned WIN_BITS = 32 * W;
  localparam int unsigned CMP_BITS = 24 + 8 * PAT_BYTES;
  localparam int unsigned FILL_W   = $clog2(W) + 1;

  entry_t                        entries [NUM_ENTRIES];
  logic [WIN_BITS-1:0]           window;
  logic [FILL_W-1:0]             fill;
  logic [NUM_ENTRIES-1:0][3:0]   hits;
  logic                          hit_any;
  logic [IDX_W-1:0]              win_idx;
  logic [1:0]                    win_off;
  logic                          primed;

  // History words, oldest in the low bits; the window appends the incoming word on top.
  if (W > 1) begin : g_hist
    logic [WIN_BITS-33:0] hist;

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        hist <= '0;
      end else if (data_valid) begin
        hist <= window[WIN_BITS-1:32];
      end
    end

    assign window = {data_in, hist};
  end else begin : g_nohist
    assign window = data_in;
  end

  // Entry table; writes land at the edge so same-cycle compares see the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_idx) < NUM_ENTRIES)) begin
      entries[cfg_idx].pattern <= MAX_PAT_BITS'(cfg_pattern);
      entries[cfg_idx].mask    <= MAX_PAT_BITS'(cfg_mask);
      entries[cfg_idx].enable  <= cfg_enable;
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
    ip_entry_compare #(
      .PAT_BYTES (PAT_BYTES)
    ) u_cmp (
      .window (window[CMP_BITS-1:0]),
      .entry  (entries[g]),
      .hit    (hits[g])
    );
  end

  // Scan from the top down so the lowest entry, then lowest offset, wins.
  always_comb begin
    hit_any = 1'b0;
    win_idx = '0;
    win_off = '0;
    for (int e = int'(NUM_ENTRIES) - 1; e >= 0; e--) begin
      for (int k = 3; k >= 0; k--) begin
        if (hits[e][k]) begin
          hit_any = 1'b1;
          win_idx = IDX_W'(e);
          win_off = 2'(k);
        end
      end
    end
  end

  assign primed = (fill >= FILL_W'(W - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fill           <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      match          <= 1'b0;
      match_idx      <= '0;
      match_offset   <= '0;
      match_count    <= '0;
    end else if (data_valid && primed) begin
      data_out       <= window[31:0];
      data_out_valid <= 1'b1;
      match          <= hit_any;
      match_idx      <= win_idx;
      match_offset   <= win_off;
      if (hit_any && (match_count != '1)) begin
        match_count <= match_count + COUNT_W'(1);
      end
    end else begin
      if (data_valid) begin
        fill <= fill + FILL_W'(1);
      end
      data_out_valid <= 1'b0;
      match          <= 1'b0;
      match_idx      <= '0;
      match_offset   <= '0;
    end
  end

endmodule

// File: tb/tb_ip_match_engine.sv
// Randomized and directed bench for ip_match_engine against a word-queue reference model.
module tb_ip_match_engine;

  localparam int NE = 4;
  localparam int PB = 4;
  localparam int W  = (PB + 6) / 4;

  bit          clk;
  logic        rst, clear, data_valid, cfg_we, cfg_enable;
  logic [31:0] data_in, cfg_pattern, cfg_mask;
  logic [1:0]  cfg_idx;
  logic [31:0] data_out;
  logic        data_out_valid, match;
  logic [1:0]  match_idx, match_offset;
  logic [15:0] match_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_pat [NE];
  logic [31:0] m_msk [NE];
  bit          m_en  [NE];
  logic [31:0] e_do;
  bit          e_v, e_m;
  int          e_i, e_o;
  int          e_cnt;

  ip_match_engine #(.NUM_ENTRIES(NE), .PAT_BYTES(PB)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_pattern    (cfg_pattern),
    .cfg_mask       (cfg_mask),
    .cfg_enable     (cfg_enable),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .match          (match),
    .match_idx      (match_idx),
    .match_offset   (match_offset),
    .match_count    (match_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_emit();
    logic [127:0] win;
    logic [31:0]  s;
    int base;
    win  = '0;
    base = q.size() - W;
    for (int i = 0; i < W; i++) win = win | (128'(q[base + i]) << (32 * i));
    e_do = q[base];
    e_v  = 1;
    e_m  = 0;
    e_i  = 0;
    e_o  = 0;
    for (int e = 0; e < NE && !e_m; e++) begin
      for (int k = 0; k < 4 && !e_m; k++) begin
        s = 32'(win >> (8 * k));
        if (m_en[e] && (((s ^ m_pat[e]) & m_msk[e]) == 32'd0)) begin
          e_m = 1;
          e_i = e;
          e_o = k;
        end
      end
    end
    if (e_m && e_cnt < 16'hFFFF) e_cnt++;
  endtask

  task automatic step(input bit r, input bit cl, input bit dv, input logic [31:0] din,
                      input bit we, input logic [1:0] idx, input logic [31:0] pat,
                      input logic [31:0] msk, input bit en);
    @(negedge clk);
    rst = r; clear = cl; data_valid = dv; data_in = din;
    cfg_we = we; cfg_idx = idx; cfg_pattern = pat; cfg_mask = msk; cfg_enable = en;
    if (r) begin
      q.delete();
      e_do = 0; e_v = 0; e_m = 0; e_i = 0; e_o = 0; e_cnt = 0;
      for (int e = 0; e < NE; e++) begin m_pat[e] = 0; m_msk[e] = 0; m_en[e] = 0; end
    end else begin
      if (cl) begin
        q.delete();
        e_do = 0; e_v = 0; e_m = 0; e_i = 0; e_o = 0; e_cnt = 0;
      end else if (dv) begin
        q.push_back(din);
        if (q.size() >= W) model_emit();
        else begin e_v = 0; e_m = 0; e_i = 0; e_o = 0; end
        while (q.size() > W - 1) void'(q.pop_front());
      end else begin
        e_v = 0; e_m = 0; e_i = 0; e_o = 0;
      end
      if (we) begin m_pat[idx] = pat; m_msk[idx] = msk; m_en[idx] = en; end
    end
    @(posedge clk);
    #1;
    check_eq("valid",  64'(data_out_valid), 64'(e_v));
    check_eq("match",  64'(match),          64'(e_m));
    check_eq("idx",    64'(match_idx),      64'(e_i));
    check_eq("offset", 64'(match_offset),   64'(e_o));
    check_eq("dout",   64'(data_out),       64'(e_do));
    check_eq("count",  64'(match_count),    64'(e_cnt));
  endtask

  task automatic beat(input logic [31:0] d);
    step(0, 0, 1, d, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] pat, input logic [31:0] msk, input bit en);
    step(0, 0, 0, 0, 1, idx, pat, msk, en);
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] alpha [4];
    logic [31:0] w;
    alpha[0] = 8'hC0; alpha[1] = 8'hA8; alpha[2] = 8'h01; alpha[3] = 8'h00;
    w = 0;
    for (int b = 0; b < 4; b++) w = w | (32'(alpha[$urandom_range(0, 3)]) << (8 * b));
    return w;
  endfunction

  function automatic logic [31:0] rand_mask();
    case ($urandom_range(0, 6))
      0, 1:    return 32'hFFFFFFFF;
      2:       return 32'hFFFF0000;
      3:       return 32'h0000FFFF;
      4:       return 32'hFF00FF00;
      5:       return $urandom();
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    rst = 1; clear = 0; data_valid = 0; data_in = 0;
    cfg_we = 0; cfg_idx = 0; cfg_pattern = 0; cfg_mask = 0; cfg_enable = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'hDEADBEEF, 1, 0, 32'h1, 32'h1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Exact match at offset 0
    cfg(0, 32'hC0A80101, 32'hFFFFFFFF, 1);
    beat(32'hC0A80101);
    beat(32'h00000000);
    check_eq("r036_off0_count", 64'(match_count), 64'd1);

    // Straddling matches at offsets 3, 2, 1
    beat(32'h01000000);
    beat(32'h00C0A801);
    check_eq("r037_off3", 64'(match_offset), 64'd3);
    beat(32'h01010000);
    beat(32'h0000C0A8);
    check_eq("r037_off2", 64'(match_offset), 64'd2);
    beat(32'hA8010100);
    beat(32'h000000C0);
    check_eq("r037_off1", 64'(match_offset), 64'd1);

    // Priority by entry index and partial masks
    cfg(0, 32'h0, 32'h0, 0);
    cfg(1, 32'hC0A80000, 32'hFFFF0000, 1);
    beat(32'hC0A8FF07);
    beat(32'h00000000);
    check_eq("r038_idx1", 64'(match_idx), 64'd1);
    cfg(0, 32'hC0A8FF07, 32'hFFFFFFFF, 1);
    beat(32'hC0A8FF07);
    beat(32'h00000000);
    check_eq("r038_idx0", 64'(match_idx), 64'd0);

    // Clear discards history and a simultaneous beat, keeps entries
    cfg(0, 32'hC0A80101, 32'hFFFFFFFF, 1);
    beat(32'h01000000);
    step(0, 1, 1, 32'hC0A80101, 0, 0, 0, 0, 0);
    beat(32'h00C0A801);
    check_eq("r039_valid", 64'(data_out_valid), 64'd0);
    beat(32'h00000000);
    check_eq("r039_match", 64'(match), 64'd0);
    check_eq("r039_count", 64'(match_count), 64'd0);
    step(0, 1, 0, 0, 1, 3, 32'h0, 32'h0, 1);

    // Saturation with an all-zero mask (hits on every emitted word)
    cfg(0, 32'h0, 32'h0, 0);
    cfg(1, 32'h0, 32'h0, 0);
    beat(32'h12345678);
    for (int i = 0; i < 16'hFFFE; i++) beat($urandom());
    check_eq("r040_fffe", 64'(match_count), 64'hFFFE);
    beat($urandom());
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    beat($urandom());
    check_eq("r040_sat", 64'(match_count), 64'hFFFF);
    check_eq("r040_zero_mask_off", 64'(match_offset), 64'd0);
    beat($urandom());
    check_eq("r040_hold", 64'(match_count), 64'hFFFF);

    // Randomized mix of traffic, configuration, clears and resets
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int e = 0; e < NE; e++) cfg(2'(e), rand_word(), rand_mask(), $urandom_range(0, 3) != 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, cl, dv, we;
      r  = ($urandom_range(0, 199) == 0);
      cl = ($urandom_range(0, 49) == 0);
      dv = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 11) == 0);
      step(r, cl, dv, rand_word(), we, 2'($urandom_range(0, 3)), rand_word(), rand_mask(),
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_match_engine.md
IP_MATCH_ENGINE -- requirements
Module: ip_match_engine

Interface
REQ-001 SHALL have parameters: NUM_ENTRIES, default 4, number of pattern entries (1..16); PAT_BYTES, default 4, pattern length in bytes (1..8).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 clear  input  1  stream restart; flushes history, outputs and counter.
REQ-006 data_valid  input  1  data_in carries a beat this cycle.
REQ-007 data_in  input  32  stream word; later stream bytes in higher bits.
REQ-008 cfg_we  input  1  entry write strobe.
REQ-009 cfg_idx  input  $clog2(NUM_ENTRIES) (min 1)  entry written.
REQ-010 cfg_pattern  input  PAT_BYTES*8  pattern value.
REQ-011 cfg_mask  input  PAT_BYTES*8  per-bit compare enable; 1 = compare.
REQ-012 cfg_enable  input  1  entry enable.
REQ-013 data_out  output  32  delayed stream word.
REQ-014 data_out_valid  output  1  one-cycle pulse per emitted word.
REQ-015 match  output  1  pattern found starting in emitted word.
REQ-016 match_idx  output  $clog2(NUM_ENTRIES) (min 1)  winning entry.
REQ-017 match_offset  output  2  starting byte offset in emitted word.
REQ-018 match_count  output  16  saturating count of matched words.

Function
REQ-019 W SHALL equal ceil((PAT_BYTES+3)/4); the block holds W-1 history words plus a fill counter.
REQ-020 Window on accepted beat n SHALL be {word n, ..., word n-W+1}, with word n-W+1 in bits [31:0].
REQ-021 Entry e SHALL hit at offset k (0..3) when enabled and (window[8k+8*PAT_BYTES-1:8k] XOR pattern) AND mask == 0.
REQ-022 On the edge accepting beat n with fill >= W-1, data_out SHALL load word n-W+1, data_out_valid = 1, match = any hit.
REQ-023 Winner SHALL be the lowest entry index, then the lowest offset; match_idx and match_offset SHALL be 0 when match = 0.
REQ-024 Cycles with no accepted beat, or with fill < W-1, SHALL drive data_out_valid = 0 and match = 0; data_out holds its value.
REQ-025 Pipeline latency SHALL be one clock after acceptance of beat n; words n-W+2..n remain held until further beats arrive.
REQ-026 match_count SHALL increment on each emitted word with match = 1 and saturate at 16'hFFFF.
REQ-027 clear SHALL zero the history, fill, data_out, data_out_valid, match, match_idx, match_offset and match_count, and override a simultaneous data_valid (that beat is discarded). Entry table is retained.
REQ-028 cfg_we SHALL update the entry at the edge; compares in the same cycle use the old entry, later beats use the new one.
REQ-029 cfg_we together with clear or data_valid SHALL all take effect.
REQ-030 A mask of all zeros on an enabled entry SHALL hit at offset 0 on every emitted word.

Reset
REQ-031 rst SHALL zero every register, including outputs, match_count, fill, and all entry pattern, mask and enable fields.
REQ-032 rst SHALL take precedence over clear, data_valid and cfg_we.
REQ-033 Reset mid-stream SHALL discard all history; the first emitted word after reset SHALL need W-1 new beats plus one.

Structure
REQ-034 A shared package SHALL hold the entry struct (pattern, mask, enable), the W function and the 16-bit count width constant.
REQ-035 One sub-module, ip_entry_compare, SHALL evaluate one entry across offsets 0..3 and return a hit vector; the top instantiates it NUM_ENTRIES times.

Verification (defaults: PAT_BYTES = 4, W = 2)
REQ-036 Entry0 = C0A80101, mask FFFFFFFF, enabled; beats C0A80101, 00000000 -> one cycle after the second beat: data_out = C0A80101, match = 1, idx 0, offset 0, match_count = 1.
REQ-037 Same entry; beats 01000000, 00C0A801 -> data_out = 01000000, match = 1, offset 3; offsets 1 and 2 are checked with 01010000/0000C0A8 and A8010100/000000C0.
REQ-038 Entry0 disabled; entry1 = C0A80000, mask FFFF0000; beats C0A8FF07, 0 -> match = 1, idx 1, offset 0; then enable both entries with entry0 = C0A8FF07 -> idx 0.
REQ-039 Beat 01000000, then clear, then 00C0A801, 0 -> no match, data_out_valid = 0 on the first post-clear beat, match_count = 0.
REQ-040 Force match_count to FFFE with repeated matching beats, then two more hits -> match_count holds at FFFF; data_valid gaps between beats -> no extra data_out_valid pulses.
